uart_tx_arbiter: RTL and testbench
==================================

// Module: uart_tx_arbiter
// PURPOSE
//  Shares the slave-side UART transmit byte port between two frame-oriented requesters.
//  Requester 0 is the command/echo path; requester 1 is the science data path.
//  Frames are locked: once granted, a requester keeps the port until its last byte.
//  Requesters are served round-robin.
//  Also owns the runtime slave TX config (baud, parity, stopbit) and applies new values
//  only at a frame boundary while the UART is idle.
// PARAMETERS
//  DEF_BAUD      115200  baud value driven out of reset
//  DEF_PARITY    0       parity value driven out of reset
//  DEF_STOPBIT   2'b11   stopbit value driven out of reset
//  SETTLE_CYC    2       cycles after a uart_send pulse during which uart_ready is ignored
//  LOCK_TIMEOUT  1200    idle cycles allowed mid-frame before the lock is revoked (16-bit counter)
// PORTS
//  clk            in   1   system clock
//  rst_n          in   1   synchronous active-low reset
//  req0_valid     in   1   requester 0 byte available
//  req0_data      in   8   requester 0 byte
//  req0_last      in   1   marks the last byte of requester 0's frame
//  req0_ready     out  1   requester 0 byte accepted this cycle
//  req1_valid     in   1   requester 1 byte available
//  req1_data      in   8   requester 1 byte
//  req1_last      in   1   marks the last byte of requester 1's frame
//  req1_ready     out  1   requester 1 byte accepted this cycle
//  uart_send      out  1   1-cycle send strobe to the UART TX
//  uart_tx_data   out  8   byte to the UART TX, valid while uart_send=1
//  uart_ready     in   1   UART TX idle
//  cfg_wr         in   1   write shadow config
//  cfg_baud_in    in   32  new baud value
//  cfg_parity_in  in   1   new parity value
//  cfg_stopbit_in in   2   new stopbit value
//  baud           out  32  applied baud, to the UART
//  parity         out  1   applied parity, to the UART
//  stopbit        out  2   applied stopbit, to the UART
//  cfg_pending    out  1   shadow config is written but not yet applied
//  grant          out  2   one-hot current owner; 00 means no owner
//  busy           out  1   a frame is in progress
//  lock_err       out  1   1-cycle pulse when the lock is revoked by timeout
// BEHAVIOUR
//  Reset values:
//   - uart_send=0, uart_tx_data=0, reqN_ready=0, grant=00, busy=0, cfg_pending=0, lock_err=0.
//   - baud/parity/stopbit = DEF_*; round-robin pointer favours req0.
//  Reset mid-frame: controller returns to IDLE; a byte already inside the UART is not aborted.
//  States:
//   - IDLE: if cfg_pending and uart_ready -> APPLY.
//     Else if any reqN_valid: grant the requester not served last (if both valid), or the only
//     one valid; set grant and busy -> SEND. Config has priority over a new frame.
//   - SEND: reqN_ready = (owner==N) & reqN_valid & uart_ready (combinational).
//     On accept: latch data and last; next cycle uart_send=1 for exactly 1 cycle with
//     uart_tx_data; -> SETTLE.
//     If the owner's valid stays low, the timeout counter increments. At LOCK_TIMEOUT:
//     lock_err pulses, grant=00, busy=0, pointer advances past the owner -> IDLE.
//     The counter clears on every accept.
//   - SETTLE: count SETTLE_CYC cycles, ignoring uart_ready -> WAITRDY.
//   - WAITRDY: on uart_ready: if the latched last=1 -> IDLE (grant=00, busy=0, pointer = owner);
//     else -> SEND.
//   - APPLY: one cycle; copy shadow to baud/parity/stopbit; clear cfg_pending -> IDLE.
//  Handshake rules:
//   - The non-owner's ready is always 0.
//   - Bytes are never interleaved between requesters inside a frame.
//   - A frame may be a single byte (last=1 on the first byte).
//  Config rules:
//   - cfg_wr sets cfg_pending=1 and overwrites the shadow; the latest write wins.
//   - cfg_wr in the APPLY cycle: APPLY copies the previous shadow; the new value is captured
//     and cfg_pending stays 1.
//  Throughput: at most one byte per UART frame time plus 2+SETTLE_CYC cycles.
// TESTING
//  1. req0 frame A1,A2,A3 (last on A3), uart model busy 10 cycles per byte -> 3 uart_send
//     pulses with A1,A2,A3; grant=01 throughout; then grant=00, busy=0.
//  2. After reset, req0 and req1 both valid with 1-byte frames, repeated
//     -> grants 01,10,01,10 in that order.
//  3. req1 frame B0..B3 in progress; req0 raises valid at B1
//     -> no req0 byte until after B3; req0 granted next.
//  4. cfg_wr baud=9600 during byte 2 of a 4-byte frame -> baud stays 115200 through byte 4;
//     APPLY after the last byte with uart_ready=1; baud=9600, cfg_pending=0 before the next grant.
//  5. Owner drops valid mid-frame for LOCK_TIMEOUT cycles -> lock_err 1-cycle pulse;
//     the other valid requester is granted 2 cycles later.
//  6. rst_n=0 for 1 cycle mid-frame -> all outputs at reset values next cycle;
//     a fresh frame then completes normally.

Source files
------------

// File: rtl/uart_tx_arbiter_if.sv
// Byte handshake bundle between the two requesters, the arbiter and the UART TX.
// The arbiter sits on the slave modport; requesters and the UART model use master.
interface uart_tx_arbiter_if;
  logic       req0_valid;
  logic [7:0] req0_data;
  logic       req0_last;
  logic       req0_ready;
  logic       req1_valid;
  logic [7:0] req1_data;
  logic       req1_last;
  logic       req1_ready;
  logic       uart_send;
  logic [7:0] uart_tx_data;
  logic       uart_ready;

  modport slave (
    input  req0_valid, req0_data, req0_last,
    input  req1_valid, req1_data, req1_last,
    input  uart_ready,
    output req0_ready, req1_ready,
    output uart_send, uart_tx_data
  );

  modport master (
    output req0_valid, req0_data, req0_last,
    output req1_valid, req1_data, req1_last,
    output uart_ready,
    input  req0_ready, req1_ready,
    input  uart_send, uart_tx_data
  );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin, frame-locked arbiter for the UART TX byte port with a shadowed
// runtime config (baud/parity/stopbit) applied only between frames while the UART is idle.
//
//  state     | meaning
//  ----------+-----------------------------------------------------------
//  S_IDLE    | no owner; apply pending config first, else grant a requester
//  S_SEND    | owner holds the port; accept its next byte when the UART is ready
//  S_SETTLE  | uart_send pulse issued; uart_ready ignored for SETTLE_CYC cycles
//  S_WAITRDY | wait for the UART to finish the byte; end frame on latched last
//  S_APPLY   | copy the shadow config to the live outputs
module uart_tx_arbiter #(
  parameter logic [31:0] DEF_BAUD     = 32'd115200,
  parameter logic        DEF_PARITY   = 1'b0,
  parameter logic [1:0]  DEF_STOPBIT  = 2'b11,
  parameter int          SETTLE_CYC   = 2,
  parameter int          LOCK_TIMEOUT = 1200
) (
  input  logic               clk,
  input  logic               rst_n,
  uart_tx_arbiter_if.slave   bus,
  input  logic               cfg_wr,
  input  logic [31:0]        cfg_baud_in,
  input  logic               cfg_parity_in,
  input  logic [1:0]         cfg_stopbit_in,
  output logic [31:0]        baud,
  output logic               parity,
  output logic [1:0]         stopbit,
  output logic               cfg_pending,
  output logic [1:0]         grant,
  output logic               busy,
  output logic               lock_err
);

  typedef enum logic [2:0] {
    S_IDLE, S_SEND, S_SETTLE, S_WAITRDY, S_APPLY
  } state_t;

  localparam logic [7:0]  SETTLE_LAST = 8'(SETTLE_CYC - 1);
  localparam logic [15:0] TO_LAST     = 16'(LOCK_TIMEOUT - 1);

  state_t      state, state_nx;
  logic        last_served;      // 1: req1 was served last, so req0 wins a tie
  logic [7:0]  settle_cnt;
  logic [15:0] to_cnt;
  logic        last_q;
  logic        uart_send_q;
  logic [7:0]  tx_data_q;
  logic [31:0] shadow_baud;
  logic        shadow_parity;
  logic [1:0]  shadow_stopbit;

  logic        owner_valid;
  logic [7:0]  owner_data;
  logic        owner_last;
  logic        pick1;
  logic        accept;
  logic        timeout;
  logic        do_grant;
  logic        frame_done;
  logic        do_apply;

  assign owner_valid = grant[1] ? bus.req1_valid : bus.req0_valid;
  assign owner_data  = grant[1] ? bus.req1_data  : bus.req0_data;
  assign owner_last  = grant[1] ? bus.req1_last  : bus.req0_last;
  assign pick1       = bus.req1_valid & (~bus.req0_valid | ~last_served);
  assign accept      = (state == S_SEND) & owner_valid & bus.uart_ready;
  assign timeout     = (state == S_SEND) & ~owner_valid & (to_cnt == TO_LAST);

  assign bus.req0_ready   = (state == S_SEND) & grant[0] & bus.req0_valid & bus.uart_ready;
  assign bus.req1_ready   = (state == S_SEND) & grant[1] & bus.req1_valid & bus.uart_ready;
  assign bus.uart_send    = uart_send_q;
  assign bus.uart_tx_data = tx_data_q;

  always_ff @(posedge clk) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx   = state;
    do_grant   = 1'b0;
    frame_done = 1'b0;
    do_apply   = 1'b0;
    case (state)
      S_IDLE: begin
        if (cfg_pending && bus.uart_ready) begin
          state_nx = S_APPLY;
        end else if (bus.req0_valid || bus.req1_valid) begin
          state_nx = S_SEND;
          do_grant = 1'b1;
        end
      end
      S_SEND: begin
        if (accept)       state_nx = S_SETTLE;
        else if (timeout) state_nx = S_IDLE;
      end
      S_SETTLE: begin
        if (settle_cnt == SETTLE_LAST) state_nx = S_WAITRDY;
      end
      S_WAITRDY: begin
        if (bus.uart_ready) begin
          if (last_q) begin
            state_nx   = S_IDLE;
            frame_done = 1'b1;
          end else begin
            state_nx = S_SEND;
          end
        end
      end
      S_APPLY: begin
        state_nx = S_IDLE;
        do_apply = 1'b1;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      uart_send_q    <= 1'b0;
      tx_data_q      <= 8'h00;
      last_q         <= 1'b0;
      settle_cnt     <= 8'd0;
      to_cnt         <= 16'd0;
      lock_err       <= 1'b0;
      grant          <= 2'b00;
      busy           <= 1'b0;
      last_served    <= 1'b1;
      baud           <= DEF_BAUD;
      parity         <= DEF_PARITY;
      stopbit        <= DEF_STOPBIT;
      shadow_baud    <= DEF_BAUD;
      shadow_parity  <= DEF_PARITY;
      shadow_stopbit <= DEF_STOPBIT;
      cfg_pending    <= 1'b0;
    end else begin
      uart_send_q <= accept;
      if (accept) begin
        tx_data_q <= owner_data;
        last_q    <= owner_last;
      end
      lock_err   <= timeout;
      settle_cnt <= (state == S_SETTLE) ? settle_cnt + 8'd1 : 8'd0;

      // Idle time only accrues while the owner has nothing to offer.
      if ((state == S_SEND) && !accept) begin
        if (!owner_valid) to_cnt <= to_cnt + 16'd1;
      end else begin
        to_cnt <= 16'd0;
      end

      if (do_grant) begin
        grant <= pick1 ? 2'b10 : 2'b01;
        busy  <= 1'b1;
      end else if (frame_done || timeout) begin
        grant       <= 2'b00;
        busy        <= 1'b0;
        last_served <= grant[1];
      end

      if (do_apply) begin
        baud    <= shadow_baud;
        parity  <= shadow_parity;
        stopbit <= shadow_stopbit;
      end
      if (cfg_wr) begin
        shadow_baud    <= cfg_baud_in;
        shadow_parity  <= cfg_parity_in;
        shadow_stopbit <= cfg_stopbit_in;
      end
      if (cfg_wr)        cfg_pending <= 1'b1;
      else if (do_apply) cfg_pending <= 1'b0;
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed and randomized checks of uart_tx_arbiter against a queue-based frame
// scoreboard and a simple busy-counter UART model.
module tb_uart_tx_arbiter;
  localparam int LT     = 1200;
  localparam int BUDGET = 4000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cfg_wr = 1'b0;
  logic [31:0] cfg_baud_in = 32'd0;
  logic        cfg_parity_in = 1'b0;
  logic [1:0]  cfg_stopbit_in = 2'b00;
  logic [31:0] baud;
  logic        parity;
  logic [1:0]  stopbit;
  logic        cfg_pending;
  logic [1:0]  grant;
  logic        busy;
  logic        lock_err;

  always #5 clk = ~clk;

  uart_tx_arbiter_if bus ();

  uart_tx_arbiter #(.LOCK_TIMEOUT(LT)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus),
    .cfg_wr(cfg_wr), .cfg_baud_in(cfg_baud_in), .cfg_parity_in(cfg_parity_in),
    .cfg_stopbit_in(cfg_stopbit_in), .baud(baud), .parity(parity), .stopbit(stopbit),
    .cfg_pending(cfg_pending), .grant(grant), .busy(busy), .lock_err(lock_err)
  );

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  int ubusy = 0;
  logic uart_rand = 1'b0;
  logic snd_seen = 1'b0;
  logic [1:0] frame_own = 2'b00;

  logic [8:0]  exp_q0[$];
  logic [8:0]  exp_q1[$];
  logic [7:0]  s_data[$];
  logic [1:0]  s_owner[$];
  logic [31:0] s_baud[$];
  logic        s_pend[$];

  logic [31:0] m_baud;
  logic        m_par;
  logic [1:0]  m_stop;

  assign bus.uart_ready = (ubusy == 0);

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // UART model: a byte keeps the UART busy for a number of cycles after its send pulse.
  initial forever begin
    @(posedge clk);
    #1;
    cyc++;
    if (snd_seen) ubusy = uart_rand ? int'($urandom_range(12, 1)) : 10;
    else if (ubusy > 0) ubusy--;
  end

  // Scoreboard: every sent byte must be the owner's next expected byte, frames unbroken.
  initial begin : monitor
    logic [1:0] own;
    logic [8:0] ent;
    forever begin
      @(negedge clk);
      snd_seen = bus.uart_send;
      if (!rst_n || lock_err) frame_own = 2'b00;
      if (rst_n) begin
        if (bus.req0_valid && grant != 2'b01) check("ready0_nonowner", 32'(bus.req0_ready), 0);
        if (bus.req1_valid && grant != 2'b10) check("ready1_nonowner", 32'(bus.req1_ready), 0);
        if (bus.uart_send) begin
          own = grant;
          check("send_grant_onehot", 32'((own == 2'b01) || (own == 2'b10)), 1);
          ent = 9'bx;
          if (own == 2'b01 && exp_q0.size() > 0) ent = exp_q0.pop_front();
          if (own == 2'b10 && exp_q1.size() > 0) ent = exp_q1.pop_front();
          check("send_data", 32'(bus.uart_tx_data), 32'(ent[7:0]));
          if (frame_own != 2'b00) check("frame_interleave", 32'(own), 32'(frame_own));
          frame_own = ent[8] ? 2'b00 : own;
          s_data.push_back(bus.uart_tx_data);
          s_owner.push_back(own);
          s_baud.push_back(baud);
          s_pend.push_back(cfg_pending);
        end
      end
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic clear_log();
    s_data.delete(); s_owner.delete(); s_baud.delete(); s_pend.delete();
  endtask

  task automatic do_reset(input int n);
    rst_n = 1'b0;
    repeat (n) begin @(posedge clk); #1; end
    rst_n = 1'b1;
    exp_q0.delete(); exp_q1.delete();
    m_baud = 32'd115200; m_par = 1'b0; m_stop = 2'b11;
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_send"},    32'(bus.uart_send), 0);
    check({tag, "_txdata"},  32'(bus.uart_tx_data), 0);
    check({tag, "_ready0"},  32'(bus.req0_ready), 0);
    check({tag, "_ready1"},  32'(bus.req1_ready), 0);
    check({tag, "_grant"},   32'(grant), 0);
    check({tag, "_busy"},    32'(busy), 0);
    check({tag, "_pending"}, 32'(cfg_pending), 0);
    check({tag, "_lockerr"}, 32'(lock_err), 0);
    check({tag, "_baud"},    baud, 32'd115200);
    check({tag, "_parity"},  32'(parity), 0);
    check({tag, "_stopbit"}, 32'(stopbit), 3);
  endtask

  task automatic drive_byte(input int r, input logic [7:0] d, input logic lst);
    int n = 0;
    logic got = 1'b0;
    if (r == 0) begin
      bus.req0_valid = 1'b1; bus.req0_data = d; bus.req0_last = lst; exp_q0.push_back({lst, d});
    end else begin
      bus.req1_valid = 1'b1; bus.req1_data = d; bus.req1_last = lst; exp_q1.push_back({lst, d});
    end
    while (!got && n < BUDGET) begin
      @(negedge clk);
      got = (r == 0) ? bus.req0_ready : bus.req1_ready;
      @(posedge clk); #1;
      n++;
    end
    check((r == 0) ? "accept0" : "accept1", 32'(got), 1);
    if (r == 0) begin bus.req0_valid = 1'b0; bus.req0_last = 1'b0; end
    else        begin bus.req1_valid = 1'b0; bus.req1_last = 1'b0; end
  endtask

  task automatic drive_frame(input int r, input int len, input logic [7:0] base, input int gap);
    for (int i = 0; i < len; i++) begin
      int g;
      logic [7:0] d;
      g = (gap > 0) ? int'($urandom_range(gap, 0)) : 0;
      repeat (g) begin @(posedge clk); #1; end
      d = (base != 8'h00) ? 8'(int'(base) + i) : 8'($urandom);
      drive_byte(r, d, (i == len - 1));
    end
  endtask

  task automatic cfg_write(input logic [31:0] b, input logic p, input logic [1:0] s);
    cfg_wr = 1'b1; cfg_baud_in = b; cfg_parity_in = p; cfg_stopbit_in = s;
    @(posedge clk); #1;
    cfg_wr = 1'b0;
    m_baud = b; m_par = p; m_stop = s;
  endtask

  task automatic wait_idle();
    int n = 0;
    do begin @(negedge clk); n++; end
    while ((busy || !bus.uart_ready || cfg_pending) && n < BUDGET);
    check("idle_reached", 32'(n < BUDGET), 1);
  endtask

  task automatic wait_sends(input int cnt, input string tag);
    int n = 0;
    while (s_data.size() < cnt && n < BUDGET) begin @(negedge clk); n++; end
    check(tag, 32'(s_data.size() >= cnt), 1);
  endtask

  initial begin
    logic [1:0] exp_own2 [4];
    int k, t_rdy, t_le;
    exp_own2 = '{2'b01, 2'b10, 2'b01, 2'b10};
    bus.req0_valid = 1'b0; bus.req0_data = 8'h00; bus.req0_last = 1'b0;
    bus.req1_valid = 1'b0; bus.req1_data = 8'h00; bus.req1_last = 1'b0;

    do_reset(3);
    @(negedge clk);
    check_reset("rst");

    // 1: three-byte frame from req0
    clear_log();
    drive_frame(0, 3, 8'hA1, 0);
    wait_idle();
    check("t1_count", s_data.size(), 3);
    for (int i = 0; i < 3; i++) begin
      check("t1_data", 32'(s_data[i]), 32'(8'hA1 + i));
      check("t1_owner", 32'(s_owner[i]), 32'b01);
    end
    check("t1_grant_end", 32'(grant), 0);
    check("t1_busy_end", 32'(busy), 0);

    // 2: round robin of single-byte frames after reset
    do_reset(1);
    clear_log();
    fork
      begin drive_frame(0, 1, 8'h00, 0); drive_frame(0, 1, 8'h00, 0); end
      begin drive_frame(1, 1, 8'h00, 0); drive_frame(1, 1, 8'h00, 0); end
    join
    wait_idle();
    check("t2_count", s_data.size(), 4);
    for (int i = 0; i < 4; i++) check("t2_owner", 32'(s_owner[i]), 32'(exp_own2[i]));

    // 3: req0 arrives mid-frame of req1
    clear_log();
    fork
      drive_frame(1, 4, 8'hB0, 0);
      begin wait_sends(2, "t3_b1_sent"); drive_frame(0, 1, 8'hC0, 0); end
    join
    wait_idle();
    check("t3_count", s_data.size(), 5);
    for (int i = 0; i < 4; i++) begin
      check("t3_data", 32'(s_data[i]), 32'(8'hB0 + i));
      check("t3_owner", 32'(s_owner[i]), 32'b10);
    end
    check("t3_req0_data", 32'(s_data[4]), 32'hC0);
    check("t3_req0_owner", 32'(s_owner[4]), 32'b01);

    // 4: config written mid-frame is held until the frame boundary
    clear_log();
    fork
      drive_frame(0, 4, 8'h40, 0);
      begin
        wait_sends(2, "t4_byte2_sent");
        cfg_write(32'd9600, 1'b1, 2'b01);
        @(negedge clk);
        check("t4_pending_set", 32'(cfg_pending), 1);
        check("t4_baud_held", baud, 32'd115200);
        drive_frame(1, 1, 8'h55, 0);
      end
    join
    wait_idle();
    check("t4_count", s_data.size(), 5);
    for (int i = 0; i < 4; i++) check("t4_baud_in_frame", s_baud[i], 32'd115200);
    check("t4_next_data", 32'(s_data[4]), 32'h55);
    check("t4_next_baud", s_baud[4], 32'd9600);
    check("t4_next_pending", 32'(s_pend[4]), 0);
    check("t4_parity", 32'(parity), 1);
    check("t4_stopbit", 32'(stopbit), 1);

    // 4b: a write landing in the APPLY cycle survives as the next pending value
    cfg_write(32'd57600, 1'b0, 2'b10);
    @(posedge clk); #1;
    cfg_write(32'd230400, 1'b1, 2'b01);
    @(negedge clk);
    check("t4b_first_applied", baud, 32'd57600);
    check("t4b_still_pending", 32'(cfg_pending), 1);
    repeat (4) @(negedge clk);
    check("t4b_second_applied", baud, 32'd230400);
    check("t4b_pending_clear", 32'(cfg_pending), 0);

    // 5: owner stalls mid-frame until the lock is revoked
    clear_log();
    drive_byte(0, 8'h5A, 1'b0);
    fork
      drive_frame(1, 1, 8'h6B, 0);
      begin
        k = 0;
        while (bus.uart_ready && k < 100) begin @(negedge clk); k++; end
        while (!bus.uart_ready && k < 200) begin @(negedge clk); k++; end
        t_rdy = cyc;
        k = 0;
        while (!lock_err && k < LT + 200) begin @(negedge clk); k++; end
        t_le = cyc;
        check("t5_lock_err_seen", 32'(lock_err), 1);
        check("t5_timeout_len", 32'(t_le - t_rdy), 32'(LT + 1));
        check("t5_grant_revoked", 32'(grant), 0);
        check("t5_busy_clear", 32'(busy), 0);
        @(negedge clk);
        check("t5_lock_err_pulse", 32'(lock_err), 0);
        check("t5_other_granted", 32'(grant), 32'b10);
      end
    join
    wait_idle();
    check("t5_count", s_data.size(), 2);
    check("t5_second_data", 32'(s_data[1]), 32'h6B);

    // 6: one-cycle reset in the middle of a frame
    clear_log();
    drive_byte(0, 8'h71, 1'b0);
    wait_sends(1, "t6_first_sent");
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    exp_q0.delete(); exp_q1.delete();
    @(negedge clk);
    check_reset("t6_rst");
    drive_frame(0, 2, 8'h81, 0);
    wait_idle();
    check("t6_count", s_data.size(), 3);
    check("t6_fresh0", 32'(s_data[1]), 32'h81);
    check("t6_fresh1", 32'(s_data[2]), 32'h82);
    check("t6_grant_end", 32'(grant), 0);

    // Randomized traffic with gaps, random UART timing and random config writes
    uart_rand = 1'b1;
    fork
      for (int f = 0; f < 6; f++) begin
        repeat ($urandom_range(5, 0)) begin @(posedge clk); #1; end
        drive_frame(0, int'($urandom_range(5, 1)), 8'h00, 3);
      end
      for (int f = 0; f < 6; f++) begin
        repeat ($urandom_range(5, 0)) begin @(posedge clk); #1; end
        drive_frame(1, int'($urandom_range(5, 1)), 8'h00, 3);
      end
      for (int w = 0; w < 5; w++) begin
        repeat ($urandom_range(80, 20)) begin @(posedge clk); #1; end
        cfg_write($urandom, 1'($urandom), 2'($urandom));
      end
    join
    wait_idle();
    check("rand_q0_drained", exp_q0.size(), 0);
    check("rand_q1_drained", exp_q1.size(), 0);
    check("rand_baud", baud, m_baud);
    check("rand_parity", 32'(parity), 32'(m_par));
    check("rand_stopbit", 32'(stopbit), 32'(m_stop));
    check("rand_grant_end", 32'(grant), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
